// File: rtl/add_bfm_pkg.sv
// Shared types and widths for the adder BFM driver: FSM state encoding,
// error-counter width and latency-counter width.
package add_bfm_pkg;

  localparam int ERR_CNT_W = 16;
  localparam int LAT_W     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    PUSH = 2'd2
  } state_t;

endpackage

// File: rtl/add_bfm_fifo.sv
// Synchronous first-word-fall-through FIFO; pop_data always shows the head entry.
// Full/empty come from a registered occupancy count, so there is no write bypass.
module add_bfm_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Pointers are log2(DEPTH) wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/add_bfm_driver.sv
// Adder BFM driver: queues operand pairs, drives them to the DUT, waits LATENCY
// cycles, captures the result into a response queue. Checker build: ADD_BFM_CHECK_EN.
module add_bfm_driver
  import add_bfm_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 16,
  parameter int LATENCY = 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [WIDTH-1:0]     cmd_a,
  input  logic [WIDTH-1:0]     cmd_b,
  output logic [WIDTH-1:0]     dut_a,
  output logic [WIDTH-1:0]     dut_b,
  input  logic [WIDTH-1:0]     dut_x,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     rsp_x,
  output logic                 rsp_err,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic                 busy
);

`ifdef ADD_BFM_CHECK_EN
  localparam int RSP_W = WIDTH + 1;
`else
  localparam int RSP_W = WIDTH;
`endif
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(LATENCY);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; valid never depends on ready, and ready depends only on registered counts.
  state_t               state;
  logic [LAT_W-1:0]     cnt;
  logic [WIDTH-1:0]     x_q;
  logic                 cmd_full;
  logic                 cmd_empty;
  logic                 cmd_pop;
  logic [2*WIDTH-1:0]   cmd_head;
  logic                 rsp_full;
  logic                 rsp_empty;
  logic                 rsp_push;
  logic                 rsp_pop;
  logic [RSP_W-1:0]     rsp_data;
  logic [RSP_W-1:0]     rsp_head;

  assign cmd_ready = !cmd_full;
  assign cmd_pop   = (state == IDLE) && !cmd_empty;
  assign rsp_push  = (state == PUSH) && !rsp_full;
  assign rsp_valid = !rsp_empty;
  assign rsp_pop   = rsp_valid && rsp_ready;
  assign busy      = (state != IDLE) || !cmd_empty;

  add_bfm_fifo #(
    .WIDTH (2*WIDTH),
    .DEPTH (DEPTH)
  ) u_cmd_fifo (
    .clk       (clk_i),
    .reset     (reset_i),
    .push      (cmd_valid && cmd_ready),
    .push_data ({cmd_a, cmd_b}),
    .pop       (cmd_pop),
    .pop_data  (cmd_head),
    .full      (cmd_full),
    .empty     (cmd_empty)
  );

  add_bfm_fifo #(
    .WIDTH (RSP_W),
    .DEPTH (DEPTH)
  ) u_rsp_fifo (
    .clk       (clk_i),
    .reset     (reset_i),
    .push      (rsp_push),
    .push_data (rsp_data),
    .pop       (rsp_pop),
    .pop_data  (rsp_head),
    .full      (rsp_full),
    .empty     (rsp_empty)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= IDLE;
      cnt   <= '0;
      dut_a <= '0;
      dut_b <= '0;
      x_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!cmd_empty) begin
            dut_a <= cmd_head[2*WIDTH-1:WIDTH];
            dut_b <= cmd_head[WIDTH-1:0];
            cnt   <= LAT_INIT;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            x_q   <= dut_x;
            state <= PUSH;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        PUSH: begin
          // A full response queue holds the captured result here until space frees.
          if (!rsp_full) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ADD_BFM_CHECK_EN
  logic [WIDTH-1:0] ref_sum;
  logic             mis_q;

  assign ref_sum  = dut_a + dut_b;
  assign rsp_data = {x_q, mis_q};
  assign rsp_x    = rsp_valid ? rsp_head[WIDTH:1] : '0;
  assign rsp_err  = rsp_valid ? rsp_head[0] : 1'b0;

  // Operands stay on dut_a/dut_b through WAIT, so the reference is formed at capture.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mis_q <= 1'b0;
    end else if (state == WAIT && cnt == '0) begin
      mis_q <= (dut_x != ref_sum);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      err_cnt <= '0;
    end else if (rsp_push && mis_q && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`else
  assign rsp_data = x_q;
  assign rsp_x    = rsp_valid ? rsp_head : '0;
  assign rsp_err  = 1'b0;
  assign err_cnt  = '0;
`endif

endmodule

// File: tb/tb_add_bfm_driver.sv
// Directed bench for add_bfm_driver: one LATENCY=1 instance with a registered adder
// and one LATENCY=0 instance with a combinational adder.
module tb_add_bfm_driver;

`ifdef ADD_BFM_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  int          checks = 0;
  int          errors = 0;

  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_a = '0;
  logic [7:0]  cmd_b = '0;
  logic [7:0]  dut_a;
  logic [7:0]  dut_b;
  logic [7:0]  dut_x;
  logic [7:0]  add_q;
  logic        stub_zero = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [7:0]  rsp_x;
  logic        rsp_err;
  logic [15:0] err_cnt;
  logic        busy;

  logic        l0_cmd_valid = 1'b0;
  logic        l0_cmd_ready;
  logic [7:0]  l0_cmd_a = '0;
  logic [7:0]  l0_cmd_b = '0;
  logic [7:0]  l0_a;
  logic [7:0]  l0_b;
  logic [7:0]  l0_x;
  logic        l0_rsp_valid;
  logic        l0_rsp_ready = 1'b0;
  logic [7:0]  l0_rsp_x;
  logic        l0_rsp_err;
  logic [15:0] l0_err_cnt;
  logic        l0_busy;

  logic [7:0]  exp_q[$];

  always #5 clk = ~clk;

  // External adder models: registered (one-cycle) and combinational.
  always @(posedge clk) add_q <= dut_a + dut_b;
  assign dut_x = stub_zero ? 8'h00 : add_q;
  assign l0_x  = l0_a + l0_b;

  add_bfm_driver #(.WIDTH(8), .DEPTH(16), .LATENCY(1)) dut (
    .clk_i(clk), .reset_i(reset_i), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .dut_a(dut_a), .dut_b(dut_b), .dut_x(dut_x),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_x(rsp_x), .rsp_err(rsp_err),
    .err_cnt(err_cnt), .busy(busy)
  );

  add_bfm_driver #(.WIDTH(8), .DEPTH(16), .LATENCY(0)) dut0 (
    .clk_i(clk), .reset_i(reset_i), .cmd_valid(l0_cmd_valid), .cmd_ready(l0_cmd_ready),
    .cmd_a(l0_cmd_a), .cmd_b(l0_cmd_b), .dut_a(l0_a), .dut_b(l0_b), .dut_x(l0_x),
    .rsp_valid(l0_rsp_valid), .rsp_ready(l0_rsp_ready), .rsp_x(l0_rsp_x), .rsp_err(l0_rsp_err),
    .err_cnt(l0_err_cnt), .busy(l0_busy)
  );

  task automatic apply_reset();
    @(negedge clk);
    reset_i = 1'b1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    l0_cmd_valid = 1'b0;
    l0_rsp_ready = 1'b0;
    @(negedge clk);
    reset_i = 1'b0;
  endtask

  // Offer one command, count edges from accept to rsp_valid, then pop the response.
  task automatic run_one(input logic [7:0] a, input logic [7:0] b,
                         output int edges, output logic [7:0] x, output logic e);
    cmd_a = a;
    cmd_b = b;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    edges = 0;
    while (!rsp_valid && edges < 20) begin
      @(negedge clk);
      edges++;
    end
    x = rsp_x;
    e = rsp_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (dut_a !== 8'h00) begin errors++; $display("FAIL reset_dut_a got %h want 00", dut_a); end
    checks++; if (dut_b !== 8'h00) begin errors++; $display("FAIL reset_dut_b got %h want 00", dut_b); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_x !== 8'h00) begin errors++; $display("FAIL reset_rsp_x got %h want 00", rsp_x); end
    checks++; if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %b want 0", rsp_err); end
    checks++; if (err_cnt !== 16'h0000) begin errors++; $display("FAIL reset_err_cnt got %h want 0000", err_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
  endtask

  task automatic test_single_op();
    int edges;
    logic [7:0] x;
    logic e;
    apply_reset();
    run_one(8'd3, 8'd4, edges, x, e);
    checks++; if (edges !== 4) begin errors++; $display("FAIL single_latency got %0d edges want 4", edges); end
    checks++; if (x !== 8'd7) begin errors++; $display("FAIL single_rsp_x got %h want 07", x); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL single_rsp_err got %b want 0", e); end
    checks++; if (err_cnt !== 16'd0) begin errors++; $display("FAIL single_err_cnt got %0d want 0", err_cnt); end
    checks++; if (dut_a !== 8'd3 || dut_b !== 8'd4) begin errors++; $display("FAIL single_hold got %h/%h want 03/04", dut_a, dut_b); end
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_drained got valid %b busy %b want 0 0", rsp_valid, busy); end
  endtask

  task automatic test_wrap();
    int edges;
    logic [7:0] x;
    logic e;
    apply_reset();
    run_one(8'hFF, 8'h02, edges, x, e);
    checks++; if (x !== 8'h01) begin errors++; $display("FAIL wrap_rsp_x got %h want 01", x); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL wrap_rsp_err got %b want 0", e); end
    checks++; if (edges !== 4) begin errors++; $display("FAIL wrap_latency got %0d want 4", edges); end
  endtask

  task automatic test_backpressure();
    int n;
    int low;
    int cyc;
    int guard;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
    apply_reset();
    exp_q.delete();
    n = 0; low = 0; cyc = 0;
    // Capacity with rsp_ready low: 16 responses + 1 held in PUSH + 16 commands.
    while (low < 8 && cyc < 300) begin
      if (cmd_ready) begin
        a = 8'(n * 37 + 5);
        b = 8'(n * 11 + 200);
        cmd_a = a;
        cmd_b = b;
        cmd_valid = 1'b1;
        exp_q.push_back(8'(a + b));
        n++;
        low = 0;
      end else begin
        cmd_valid = 1'b0;
        low++;
      end
      @(negedge clk);
      cyc++;
    end
    cmd_valid = 1'b0;
    checks++; if (n !== 33) begin errors++; $display("FAIL bp_accepted got %0d want 33", n); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_cmd_ready got %b want 0", cmd_ready); end
    checks++; if (rsp_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL bp_stall got valid %b busy %b want 1 1", rsp_valid, busy); end
    checks++; if (dut.state !== add_bfm_pkg::PUSH) begin errors++; $display("FAIL bp_state got %0d want %0d", dut.state, add_bfm_pkg::PUSH); end
    rsp_ready = 1'b1;
    guard = 0;
    while (exp_q.size() > 0 && guard < 400) begin
      if (rsp_valid) begin
        exp = exp_q.pop_front();
        checks++;
        if (rsp_x !== exp) begin errors++; $display("FAIL bp_order got %h want %h", rsp_x, exp); end
      end
      @(negedge clk);
      guard++;
    end
    rsp_ready = 1'b0;
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL bp_missing got %0d left want 0", exp_q.size()); end
    repeat (4) @(negedge clk);
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL bp_idle got valid %b busy %b ready %b want 0 0 1", rsp_valid, busy, cmd_ready);
    end
  endtask

  task automatic test_checker();
    int edges;
    logic [7:0] x;
    logic e;
    logic [7:0] ta [3];
    logic [7:0] tb [3];
    ta[0] = 8'd1;   tb[0] = 8'd2;
    ta[1] = 8'd5;   tb[1] = 8'd5;
    ta[2] = 8'h80;  tb[2] = 8'h01;
    apply_reset();
    stub_zero = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_one(ta[i], tb[i], edges, x, e);
      checks++; if (x !== 8'h00) begin errors++; $display("FAIL chk_rsp_x[%0d] got %h want 00", i, x); end
      checks++; if (e !== CHK) begin errors++; $display("FAIL chk_rsp_err[%0d] got %b want %b", i, e, CHK); end
    end
    stub_zero = 1'b0;
    checks++; if (err_cnt !== (CHK ? 16'd3 : 16'd0)) begin
      errors++; $display("FAIL chk_err_cnt got %0d want %0d", err_cnt, CHK ? 3 : 0);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      cmd_a = 8'(i + 1);
      cmd_b = 8'(i + 10);
      cmd_valid = 1'b1;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    // First response is queued; second transaction has just entered WAIT.
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL mid_pre got valid %b busy %b want 1 1", rsp_valid, busy); end
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    checks++; if (dut_a !== 8'h00 || dut_b !== 8'h00) begin errors++; $display("FAIL mid_dut_ab got %h/%h want 00/00", dut_a, dut_b); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_busy got busy %b ready %b want 0 1", busy, cmd_ready); end
    rsp_ready = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    rsp_ready = 1'b0;
    checks++; if (seen !== 0) begin errors++; $display("FAIL mid_no_rsp got %0d valid cycles want 0", seen); end
  endtask

  task automatic test_latency0();
    int edges;
    apply_reset();
    l0_cmd_a = 8'd10;
    l0_cmd_b = 8'd20;
    l0_cmd_valid = 1'b1;
    @(negedge clk);
    l0_cmd_valid = 1'b0;
    edges = 0;
    while (!l0_rsp_valid && edges < 20) begin
      @(negedge clk);
      edges++;
    end
    checks++; if (edges !== 3) begin errors++; $display("FAIL lat0_latency got %0d edges want 3", edges); end
    checks++; if (l0_rsp_x !== 8'd30) begin errors++; $display("FAIL lat0_rsp_x got %0d want 30", l0_rsp_x); end
    checks++; if (l0_rsp_err !== 1'b0 || l0_err_cnt !== 16'd0) begin
      errors++; $display("FAIL lat0_err got %b/%0d want 0/0", l0_rsp_err, l0_err_cnt);
    end
    l0_rsp_ready = 1'b1;
    @(negedge clk);
    l0_rsp_ready = 1'b0;
    checks++; if (l0_rsp_valid !== 1'b0 || l0_busy !== 1'b0) begin
      errors++; $display("FAIL lat0_drained got valid %b busy %b want 0 0", l0_rsp_valid, l0_busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_wrap();
    test_backpressure();
    test_checker();
    test_reset_mid();
    test_latency0();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
